// File: rtl/fft16_pkg.sv
// Shared constants, FSM state type and bit-reversal helper for the 16-point FFT frame serializer.
package fft16_pkg;

    localparam int unsigned FFT_POINTS = 16;
    localparam int unsigned IDX_W      = 4;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } state_t;

    function automatic logic [IDX_W-1:0] bitrev4(input logic [IDX_W-1:0] p);
        return {p[0], p[1], p[2], p[3]};
    endfunction

endpackage

// File: rtl/fft16_frame_serializer.sv
// Captures a 16-sample complex frame and streams it out one word per ready/valid handshake.
// Define FFT16_BITREV_OUT_EN to read the bank in bit-reversed order (natural bins from a bit-reversed FFT).
module fft16_frame_serializer
    import fft16_pkg::*;
#(
    parameter int unsigned N = 16
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_load,
    input  logic [FFT_POINTS*N-1:0] i_frame_re,
    input  logic [FFT_POINTS*N-1:0] i_frame_im,
    input  logic                    i_ready,
    output logic                    o_valid,
    output logic [N-1:0]            o_re,
    output logic [N-1:0]            o_im,
    output logic [IDX_W-1:0]        o_index,
    output logic                    o_last,
    output logic                    o_busy,
    output logic                    o_overrun
);

    state_t           state;
    state_t           state_nx;
    logic [IDX_W-1:0] pos;
    logic [IDX_W-1:0] pos_d;
    logic [IDX_W-1:0] sel_d;
    logic             xfer;
    logic             at_last;
    logic             xfer_end;
    logic             accept;
    logic             advance;
    logic             overrun_d;
    logic             last_d;

    logic [N-1:0] bank_re [FFT_POINTS];
    logic [N-1:0] bank_im [FFT_POINTS];

    function automatic logic [IDX_W-1:0] out_sel(input logic [IDX_W-1:0] p);
`ifdef FFT16_BITREV_OUT_EN
        return bitrev4(p);
`else
        return p;
`endif
    endfunction

    assign o_valid  = (state == ST_STREAM);
    assign o_busy   = (state == ST_STREAM);
    assign xfer     = o_valid && i_ready;
    assign at_last  = (pos == IDX_W'(FFT_POINTS - 1));
    assign xfer_end = xfer && at_last;

    // State register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: begin
                if (i_load) begin
                    state_nx = ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (xfer_end && !i_load) begin
                    state_nx = ST_IDLE;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // Control decode: load acceptance, counter advance, overrun and next output word
    always_comb begin
        accept    = 1'b0;
        advance   = 1'b0;
        overrun_d = 1'b0;
        case (state)
            ST_IDLE: begin
                accept = i_load;
            end
            ST_STREAM: begin
                if (xfer_end) begin
                    accept = i_load;
                end else begin
                    advance   = xfer;
                    overrun_d = i_load;
                end
            end
            default: begin
                accept = 1'b0;
            end
        endcase

        pos_d = pos;
        if (accept) begin
            pos_d = '0;
        end else if (advance) begin
            pos_d = pos + IDX_W'(1);
        end
        sel_d  = out_sel(pos_d);
        last_d = (state_nx == ST_STREAM) && (pos_d == IDX_W'(FFT_POINTS - 1));
    end

    // Bank, position counter and registered output word
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            pos       <= '0;
            o_re      <= '0;
            o_im      <= '0;
            o_index   <= '0;
            o_last    <= 1'b0;
            o_overrun <= 1'b0;
            for (int unsigned k = 0; k < FFT_POINTS; k++) begin
                bank_re[k] <= '0;
                bank_im[k] <= '0;
            end
        end else begin
            pos       <= pos_d;
            o_last    <= last_d;
            o_overrun <= overrun_d;
            if (accept) begin
                for (int unsigned k = 0; k < FFT_POINTS; k++) begin
                    bank_re[k] <= i_frame_re[k*N +: N];
                    bank_im[k] <= i_frame_im[k*N +: N];
                end
                // Position 0 maps to entry 0 in either read order, so take it straight off the bus
                o_re    <= i_frame_re[N-1:0];
                o_im    <= i_frame_im[N-1:0];
                o_index <= sel_d;
            end else if (advance) begin
                o_re    <= bank_re[sel_d];
                o_im    <= bank_im[sel_d];
                o_index <= sel_d;
            end
        end
    end

endmodule

// File: tb/tb_fft16_frame_serializer.sv
// Self-checking bench for fft16_frame_serializer: table-driven frames, scoreboard of expected words, corner sequences.
module tb_fft16_frame_serializer;

    localparam int N   = 16;
    localparam int PTS = 16;

    logic              clk = 1'b0;
    logic              i_rst;
    logic              i_load;
    logic [PTS*N-1:0]  i_frame_re;
    logic [PTS*N-1:0]  i_frame_im;
    logic              i_ready;
    logic              o_valid;
    logic [N-1:0]      o_re;
    logic [N-1:0]      o_im;
    logic [3:0]        o_index;
    logic              o_last;
    logic              o_busy;
    logic              o_overrun;

    fft16_frame_serializer #(.N(N)) dut (
        .i_clk      (clk),
        .i_rst      (i_rst),
        .i_load     (i_load),
        .i_frame_re (i_frame_re),
        .i_frame_im (i_frame_im),
        .i_ready    (i_ready),
        .o_valid    (o_valid),
        .o_re       (o_re),
        .o_im       (o_im),
        .o_index    (o_index),
        .o_last     (o_last),
        .o_busy     (o_busy),
        .o_overrun  (o_overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] re;
        logic [N-1:0] im;
        logic [3:0]   idx;
        logic         last;
    } exp_t;

    typedef struct {
        int           base;
        int           mode;        // 0 always ready, 1 toggling 1,0,..., 2 random
        int           exp_cycles;  // cycles to drain 16 words, -1 when random
        logic [N-1:0] exp_first_re;
    } vec_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    logic         stall_prev = 1'b0;
    logic [63:0]  held_word  = '0;

    function automatic logic [3:0] exp_sel(input logic [3:0] p);
`ifdef FFT16_BITREV_OUT_EN
        return {p[0], p[1], p[2], p[3]};
`else
        return p;
`endif
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_frame(input int base);
        for (int k = 0; k < PTS; k++) begin
            i_frame_re[k*N +: N] = N'(base + k);
            i_frame_im[k*N +: N] = N'(-(base + k));
        end
    endtask

    task automatic push_frame(input int base);
        exp_t e;
        for (int p = 0; p < PTS; p++) begin
            e.idx  = exp_sel(4'(p));
            e.re   = N'(base + int'(e.idx));
            e.im   = N'(-(base + int'(e.idx)));
            e.last = (p == PTS - 1);
            sb.push_back(e);
        end
    endtask

    task automatic load_frame(input int base);
        set_frame(base);
        i_load = 1'b1;
        tick();
        i_load = 1'b0;
        push_frame(base);
    endtask

    // Drive i_ready per mode until the scoreboard empties; returns the number of cycles used
    task automatic drain(input int mode, input string tag, output int cycles);
        int c;
        c = 0;
        while (sb.size() != 0 && c < 400) begin
            case (mode)
                0:       i_ready = 1'b1;
                1:       i_ready = (c % 2 == 0);
                default: i_ready = 1'($urandom_range(0, 1));
            endcase
            tick();
            c++;
        end
        cycles = c;
        check({tag, "_drained"}, 64'(sb.size()), 64'd0);
        check({tag, "_valid_low_after_last"}, 64'(o_valid), 64'd0);
        check({tag, "_busy_low_after_last"}, 64'(o_busy), 64'd0);
        i_ready = 1'b0;
        sb.delete();
    endtask

    // Scoreboard and hold-stability monitor, sampled away from the active edge
    always @(negedge clk) begin
        exp_t e;
        if (i_rst) begin
            stall_prev = 1'b0;
        end else begin
            if (!o_valid) begin
                check("last_without_valid", 64'(o_last), 64'd0);
            end
            if (stall_prev && o_valid) begin
                check("stall_hold", 64'({o_re, o_im, o_index, o_last}), held_word);
            end
            if (o_valid && i_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_word", 64'(o_index), 64'hFFFF);
                end else begin
                    e = sb.pop_front();
                    check("word", 64'({o_re, o_im, o_index, o_last}),
                          64'({e.re, e.im, e.idx, e.last}));
                end
            end
            stall_prev = o_valid && !i_ready;
            held_word  = 64'({o_re, o_im, o_index, o_last});
        end
    end

    vec_t vecs[4];

    initial begin
        int cyc;
        int vcount;
        int n;

        vecs[0] = '{base: 0,      mode: 0, exp_cycles: 16, exp_first_re: 16'd0};
        vecs[1] = '{base: 0,      mode: 1, exp_cycles: 31, exp_first_re: 16'd0};
        vecs[2] = '{base: 200,    mode: 2, exp_cycles: -1, exp_first_re: 16'd200};
        vecs[3] = '{base: 'hFFF0, mode: 0, exp_cycles: 16, exp_first_re: 16'hFFF0};

        i_rst      = 1'b1;
        i_load     = 1'b0;
        i_ready    = 1'b0;
        i_frame_re = '0;
        i_frame_im = '0;
        repeat (3) tick();
        check("reset_outputs", 64'({o_valid, o_re, o_im, o_index, o_last, o_busy, o_overrun}), 64'd0);
        i_rst = 1'b0;
        repeat (2) tick();
        check("idle_no_valid", 64'(o_valid), 64'd0);

        // Table-driven frames with different ready patterns
        for (int v = 0; v < 4; v++) begin
            load_frame(vecs[v].base);
            check($sformatf("v%0d_valid_at_load_plus1", v), 64'({o_valid, o_busy}), 64'b11);
            check($sformatf("v%0d_first_word", v), 64'({o_re, o_index}), 64'({vecs[v].exp_first_re, 4'd0}));
            drain(vecs[v].mode, $sformatf("v%0d", v), cyc);
            if (vecs[v].exp_cycles >= 0) begin
                check($sformatf("v%0d_cycles", v), 64'(cyc), 64'(vecs[v].exp_cycles));
            end
            tick();
        end

        // Load while streaming at word 5: rejected with a one-cycle overrun pulse
        load_frame(0);
        i_ready = 1'b1;
        repeat (5) tick();
        check("ovr_at_word5", 64'(o_index), 64'(exp_sel(4'd5)));
        set_frame(50);
        i_load = 1'b1;
        tick();
        i_load = 1'b0;
        check("ovr_pulse_high", 64'(o_overrun), 64'd1);
        tick();
        check("ovr_pulse_low", 64'(o_overrun), 64'd0);
        drain(0, "ovr", cyc);
        tick();

        // Load coincident with the last transfer: gapless back-to-back frame
        load_frame(0);
        i_ready = 1'b1;
        n = 0;
        while (!(o_valid && o_last) && n < 20) begin
            tick();
            n++;
        end
        check("b2b_reached_last", 64'({o_valid, o_last}), 64'b11);
        set_frame(100);
        i_load = 1'b1;
        tick();
        i_load = 1'b0;
        push_frame(100);
        check("b2b_valid_stays", 64'({o_valid, o_last}), 64'b10);
        check("b2b_next_word", 64'({o_re, o_index}), 64'({16'd100, 4'd0}));
        drain(0, "b2b", cyc);
        check("b2b_cycles", 64'(cyc), 64'd16);
        tick();

        // Reset mid-frame at word 8: outputs clear at once, no words until a new load
        load_frame(0);
        i_ready = 1'b1;
        repeat (8) tick();
        check("rst_at_word8", 64'(o_index), 64'(exp_sel(4'd8)));
        i_rst = 1'b1;
        #1;
        check("rst_async_clear", 64'({o_valid, o_re, o_im, o_index, o_last, o_busy, o_overrun}), 64'd0);
        sb.delete();
        tick();
        i_rst  = 1'b0;
        vcount = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (o_valid) vcount++;
        end
        check("rst_no_words_after_release", 64'(vcount), 64'd0);
        i_ready = 1'b0;
        load_frame(7);
        check("rst_recover_first", 64'({o_valid, o_re}), 64'({1'b1, 16'd7}));
        drain(0, "recover", cyc);

        repeat (2) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
